// File: rtl/control_unit.sv
// Hardwired Moore control sequencer: fetch (T0..T2) then execute steps T3..T6
// chosen from the instruction opcode, with sticky halt on unsupported opcodes.
module control_unit #(
   parameter int OPW = 5,
   parameter int DW  = 32
) (
   input  logic           clk,
   input  logic           clr,
   input  logic [DW-1:0]  ir,
   input  logic           mem_ready,
   input  logic           stop,
   output logic           pc_out,
   output logic           zlo_out,
   output logic           zhi_out,
   output logic           mdr_out,
   output logic           mar_enable,
   output logic           pc_enable,
   output logic           mdr_enable,
   output logic           ir_enable,
   output logic           y_enable,
   output logic           z_enable,
   output logic           lo_enable,
   output logic           hi_enable,
   output logic           read,
   output logic           pc_increment,
   output logic           gra,
   output logic           grb,
   output logic           grc,
   output logic           r_in,
   output logic           r_out,
   output logic [OPW-1:0] op_code,
   output logic           run,
   output logic           illegal
);

   typedef enum logic [3:0] {RST, T0, T1, T1W, T2, T3, T4, T5, T6, HALT} state_t;

   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b00111);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01000);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01001);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);

   state_t         state;
   logic [OPW-1:0] opcode;
   logic           legal, is_muldiv, is_unary;
   logic           unused_ir;

   assign opcode    = ir[DW-1 -: OPW];
   assign unused_ir = ^ir[DW-OPW-1:0];
   assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
         OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= RST;
         illegal <= 1'b0;
      end else begin
         case (state)
            RST:  state <= T0;
            T0:   state <= T1;
            T1:   state <= mem_ready ? T2 : T1W;
            T1W:  state <= mem_ready ? T2 : T1W;
            T2:   state <= T3;
            T3: begin
               if (legal) state <= T4;
               else begin
                  state   <= HALT;
                  illegal <= 1'b1;
               end
            end
            T4:   state <= T5;
            T5:   state <= is_muldiv ? T6 : (stop ? HALT : T0);
            T6:   state <= stop ? HALT : T0;
            HALT: state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   // Outputs follow the present state; T3..T5 also look at the opcode,
   // which is stable once IR has loaded in T2.
   always_comb begin
      pc_out       = 1'b0;
      zlo_out      = 1'b0;
      zhi_out      = 1'b0;
      mdr_out      = 1'b0;
      mar_enable   = 1'b0;
      pc_enable    = 1'b0;
      mdr_enable   = 1'b0;
      ir_enable    = 1'b0;
      y_enable     = 1'b0;
      z_enable     = 1'b0;
      lo_enable    = 1'b0;
      hi_enable    = 1'b0;
      read         = 1'b0;
      pc_increment = 1'b0;
      gra          = 1'b0;
      grb          = 1'b0;
      grc          = 1'b0;
      r_in         = 1'b0;
      r_out        = 1'b0;
      op_code      = '0;
      run          = 1'b0;
      case (state)
         T0: begin
            run          = 1'b1;
            pc_out       = 1'b1;
            mar_enable   = 1'b1;
            pc_increment = 1'b1;
            z_enable     = 1'b1;
            op_code      = OP_ADD;
         end
         T1: begin
            run        = 1'b1;
            zlo_out    = 1'b1;
            pc_enable  = 1'b1;
            read       = 1'b1;
            mdr_enable = 1'b1;
         end
         T1W: begin
            run        = 1'b1;
            read       = 1'b1;
            mdr_enable = 1'b1;
         end
         T2: begin
            run       = 1'b1;
            mdr_out   = 1'b1;
            ir_enable = 1'b1;
         end
         T3: begin
            run      = 1'b1;
            grb      = 1'b1;
            r_out    = 1'b1;
            y_enable = legal;
         end
         T4: begin
            run      = 1'b1;
            op_code  = opcode;
            z_enable = 1'b1;
            r_out    = 1'b1;
            grb      = is_unary;
            grc      = !is_unary;
         end
         T5: begin
            run       = 1'b1;
            zlo_out   = 1'b1;
            lo_enable = is_muldiv;
            gra       = !is_muldiv;
            r_in      = !is_muldiv;
         end
         T6: begin
            run       = 1'b1;
            zhi_out   = 1'b1;
            hi_enable = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Cycle-by-cycle vector table for control_unit: each row drives inputs and
// queues the expected output word, which is popped and compared shortly after.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b0;
   logic        stop = 1'b0;
   logic pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable, mdr_enable, ir_enable;
   logic y_enable, z_enable, lo_enable, hi_enable, read, pc_increment;
   logic gra, grb, grc, r_in, r_out, run, illegal;
   logic [4:0] op_code;

   control_unit dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .mdr_out(mdr_out),
      .mar_enable(mar_enable), .pc_enable(pc_enable), .mdr_enable(mdr_enable),
      .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
      .lo_enable(lo_enable), .hi_enable(hi_enable), .read(read),
      .pc_increment(pc_increment), .gra(gra), .grb(grb), .grc(grc),
      .r_in(r_in), .r_out(r_out), .op_code(op_code), .run(run), .illegal(illegal)
   );

   always #5 clk = ~clk;

   localparam logic [25:0] PCO  = 26'd1 << 25, ZLO  = 26'd1 << 24, ZHI = 26'd1 << 23;
   localparam logic [25:0] MDRO = 26'd1 << 22, MARE = 26'd1 << 21, PCE = 26'd1 << 20;
   localparam logic [25:0] MDRE = 26'd1 << 19, IRE  = 26'd1 << 18, YE  = 26'd1 << 17;
   localparam logic [25:0] ZE   = 26'd1 << 16, LOE  = 26'd1 << 15, HIE = 26'd1 << 14;
   localparam logic [25:0] RD   = 26'd1 << 13, PCI  = 26'd1 << 12, GRA = 26'd1 << 11;
   localparam logic [25:0] GRB  = 26'd1 << 10, GRC  = 26'd1 << 9,  RI  = 26'd1 << 8;
   localparam logic [25:0] RO   = 26'd1 << 7,  RUN  = 26'd1 << 1,  ILL = 26'd1;

   localparam logic [25:0] E_T0   = PCO | MARE | PCI | ZE | (26'd3 << 2) | RUN;
   localparam logic [25:0] E_T1   = ZLO | PCE | RD | MDRE | RUN;
   localparam logic [25:0] E_T1W  = RD | MDRE | RUN;
   localparam logic [25:0] E_T2   = MDRO | IRE | RUN;
   localparam logic [25:0] E_T3   = GRB | RO | YE | RUN;
   localparam logic [25:0] E_T3I  = GRB | RO | RUN;
   localparam logic [25:0] E_T5   = ZLO | GRA | RI | RUN;
   localparam logic [25:0] E_T5M  = ZLO | LOE | RUN;
   localparam logic [25:0] E_T6   = ZHI | HIE | RUN;

   localparam logic [31:0] I_ADD = 32'h18918000, I_SHR = 32'h28918000, I_AND = 32'h50918000;
   localparam logic [31:0] I_MUL = 32'h78918000, I_DIV = 32'h80918000, I_NEG = 32'h88918000;
   localparam logic [31:0] I_LD  = 32'h00918000, I_BAD = 32'h60918000;

   typedef struct {
      logic        clr;
      logic [31:0] ir;
      logic        mr;
      logic        stop;
      logic [25:0] exp;
   } vec_t;

   vec_t        tbl[$];
   logic [25:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;

   function automatic logic [25:0] t4(input logic [31:0] i, input logic unary);
      return (26'(i[31:27]) << 2) | ZE | RO | (unary ? GRB : GRC) | RUN;
   endfunction

   task automatic add(input logic c, input logic [31:0] i, input logic mr,
                      input logic st, input logic [25:0] e);
      vec_t v;
      v.clr = c; v.ir = i; v.mr = mr; v.stop = st; v.exp = e;
      tbl.push_back(v);
   endtask

   // Full instruction with memory ready at once and no stop request.
   task automatic instr(input logic [31:0] i, input logic unary, input logic muldiv);
      add(1, i, 1, 0, E_T0);
      add(1, i, 1, 0, E_T1);
      add(1, i, 1, 0, E_T2);
      add(1, i, 1, 0, E_T3);
      add(1, i, 1, 0, t4(i, unary));
      add(1, i, 1, 0, muldiv ? E_T5M : E_T5);
      if (muldiv) add(1, i, 1, 0, E_T6);
   endtask

   initial begin
      logic [25:0] act, e;
      // reset, then shr / and / wait states / mul / neg / div
      add(0, I_SHR, 1, 0, '0);
      add(1, I_SHR, 1, 0, '0);
      instr(I_SHR, 0, 0);
      instr(I_AND, 0, 0);
      add(1, I_ADD, 0, 0, E_T0);
      add(1, I_ADD, 0, 0, E_T1);
      add(1, I_ADD, 0, 0, E_T1W);
      add(1, I_ADD, 0, 0, E_T1W);
      add(1, I_ADD, 1, 0, E_T1W);
      add(1, I_ADD, 1, 0, E_T2);
      add(1, I_ADD, 1, 0, E_T3);
      add(1, I_ADD, 1, 0, t4(I_ADD, 0));
      add(1, I_ADD, 1, 0, E_T5);
      instr(I_MUL, 0, 1);
      instr(I_NEG, 1, 0);
      instr(I_DIV, 0, 1);
      // stop raised in T2 completes the instruction, then halts
      add(1, I_ADD, 1, 0, E_T0);
      add(1, I_ADD, 1, 0, E_T1);
      add(1, I_ADD, 1, 1, E_T2);
      add(1, I_ADD, 1, 1, E_T3);
      add(1, I_ADD, 1, 1, t4(I_ADD, 0));
      add(1, I_ADD, 1, 1, E_T5);
      add(1, I_ADD, 1, 0, '0);
      add(1, I_ADD, 1, 0, '0);
      add(0, I_LD, 1, 0, '0);
      add(1, I_LD, 1, 0, '0);
      // unsupported opcode: halt with sticky illegal until clr
      add(1, I_LD, 1, 0, E_T0);
      add(1, I_LD, 1, 0, E_T1);
      add(1, I_LD, 1, 0, E_T2);
      add(1, I_LD, 1, 0, E_T3I);
      for (int k = 0; k < 10; k++) add(1, I_ADD, k[0], k[1], ILL);
      add(0, I_BAD, 1, 0, '0);
      add(1, I_BAD, 1, 0, '0);
      add(1, I_BAD, 1, 0, E_T0);
      add(1, I_BAD, 1, 0, E_T1);
      add(1, I_BAD, 1, 0, E_T2);
      add(1, I_BAD, 1, 0, E_T3I);
      add(1, I_BAD, 1, 0, ILL);
      add(0, I_SHR, 0, 0, '0);
      add(1, I_SHR, 0, 0, '0);
      // clr asserted mid-read
      add(1, I_SHR, 0, 0, E_T0);
      add(1, I_SHR, 0, 0, E_T1);
      add(1, I_SHR, 0, 0, E_T1W);
      add(0, I_SHR, 0, 0, '0);
      add(1, I_SHR, 0, 0, '0);
      instr(I_SHR, 0, 0);
      add(1, I_SHR, 1, 0, E_T0);

      for (int n = 0; n < tbl.size(); n++) begin
         @(negedge clk);
         clr = tbl[n].clr; ir = tbl[n].ir; mem_ready = tbl[n].mr; stop = tbl[n].stop;
         exp_q.push_back(tbl[n].exp);
         #1;
         e = exp_q.pop_front();
         act = {pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable, mdr_enable,
                ir_enable, y_enable, z_enable, lo_enable, hi_enable, read, pc_increment,
                gra, grb, grc, r_in, r_out, op_code, run, illegal};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL vec%0d outputs got=%07h exp=%07h", n, act, e);
         end
         checks++;
         if ($countones({pc_out, zlo_out, zhi_out, mdr_out, r_out}) > 1) begin
            failures++;
            $display("FAIL vec%0d bus_onehot got=%05b exp=at_most_one", n,
                     {pc_out, zlo_out, zhi_out, mdr_out, r_out});
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
